triple_checker: RTL and testbench
=================================

// Module: triple_checker
// PURPOSE
//  In-hardware verifier for Beaver-triple shares produced by two CRG instances (party 0/1).
//  Reconstructs a,b,c (arith: lane-wise add mod 2^W; bool: XOR) and checks c == a*b (arith) or c == a&b (bool).
//  Extended mode also checks e0^e1 == LSB of each reconstructed 32-bit lane of a.
//  Sits beside the CRG pair on-chip; replaces the simulation-only share check for FPGA self-test.
// PARAMETERS
//  DATA_W      256  share width; multiple of 32; LANES32 = DATA_W/32
//  CNT_W       32   width of triple index and pass/fail counters
//  MUL_STAGES  4    pipeline registers inside the lane multiplier (>=1)
// PORTS
//  clk_i          in   1        clock
//  rst_i          in   1        synchronous reset, active-high
//  start_i        in   1        pulse: latch config, clear counters, IDLE->RUN
//  clear_i        in   1        pulse: abort/flush, any state -> IDLE
//  width_i        in   3        000=32b 001=64b 011=128b 111=256b lanes; other codes -> 32b
//  mode_i         in   3        100=arith 010=bool 001=arith+extended; other -> arith
//  n_triples_i    in   CNT_W    number of triples to check
//  vld_i          in   1        share set valid this cycle
//  a0_i,b0_i,c0_i in   DATA_W   party-0 shares
//  a1_i,b1_i,c1_i in   DATA_W   party-1 shares
//  e0_i,e1_i      in   LANES32  party extended bits (ignored unless mode=001)
//  busy_o         out  1        state is RUN or DRAIN
//  done_o         out  1        state is DONE
//  pass_cnt_o     out  CNT_W    triples passing
//  fail_cnt_o     out  CNT_W    triples failing
//  first_fail_o   out  CNT_W    index (0-based, acceptance order) of first failure
//  fail_mask_o    out  LANES32  32-bit sub-lane mismatch mask of first failure
//  fail_o         out  1        sticky: at least one failure since start
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; pipeline valids 0. Reset mid-run discards everything.
//  FSM: IDLE -start_i-> RUN (if n_triples_i==0: -> DONE next cycle).
//   RUN: accept each vld_i; accepted counter acc_cnt++; when acc_cnt reaches n_triples -> DRAIN.
//   DRAIN: no acceptance; when pipeline empty and last result counted -> DONE.
//   DONE: holds results until start_i (rerun) or clear_i (-> IDLE, outputs kept until next start).
//  start_i ignored in RUN/DRAIN. clear_i beats start_i if simultaneous. vld_i ignored outside RUN.
//  width_i/mode_i/n_triples_i sampled only on the accepted start_i edge; held for whole run.
//  Pipeline: S0 reconstruct (registered), MUL_STAGES multiply, 1 compare/count stage.
//   Result of triple accepted at cycle t updates counters at t+MUL_STAGES+2.
//   Full throughput: one triple per cycle, no backpressure.
//  Arith: per lane of W bits, a=a0+a1, b=b0+b1, c=c0+c1 mod 2^W; expect c == (a*b) mod 2^W.
//  Bool: a=a0^a1 etc.; expect c == a&b bitwise; width_i ignored.
//  Extended: also e0^e1 bit k must equal reconstructed a[32k]; mismatch fails sub-lane k.
//  fail_mask: a W-bit lane mismatch sets all W/32 sub-lane bits it covers.
//  Counters saturate at 2^CNT_W-1 (no wrap). first_fail_o/fail_mask_o written only on first failure.
//  pass_cnt+fail_cnt == n_triples in DONE (unless saturated).
// TESTING
//  1 Correct a256 shares (a=3,b=5,c=15 split randomly), n=4 -> DONE after 4+MUL_STAGES+2 cycles, pass=4, fail=0.
//  2 a32, n=10, triple #6 lane 2 c off by 1 -> fail=1, pass=9, first_fail=6, fail_mask=8'h04.
//  3 a128, n=3, triple #0 high-lane error -> first_fail=0, fail_mask=8'hF0, fail_o=1.
//  4 bool128, c=a&b with a0^a1=all-ones -> pass; flip one c bit in bit 40 -> fail_mask=8'h02.
//  5 e64, correct arith but e0^e1 bit3 wrong -> fail_mask=8'h08, fail=1.
//  6 n=0 -> DONE next cycle, counts 0; clear_i mid-RUN -> IDLE, busy_o=0 next cycle, late results not counted.

Source files
------------

// File: rtl/triple_checker.sv
`default_nettype none
// ============================================================================
//  Module      : triple_checker
//  Description : On-chip verifier for Beaver-triple shares from a CRG pair.
//                Reconstructs a, b, c from two parties' shares (lane-wise
//                add or XOR), checks c == a*b or c == a&b per lane, and
//                optionally checks the parties' extended bits against the
//                LSB of each reconstructed 32-bit sub-lane of a.
//  Revision    : 1.0  initial release
// ============================================================================
module triple_checker #(
    parameter int DATA_W     = 256,
    parameter int CNT_W      = 32,
    parameter int MUL_STAGES = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 clear_i,
    input  logic [2:0]           width_i,
    input  logic [2:0]           mode_i,
    input  logic [CNT_W-1:0]     n_triples_i,
    input  logic                 vld_i,
    input  logic [DATA_W-1:0]    a0_i,
    input  logic [DATA_W-1:0]    b0_i,
    input  logic [DATA_W-1:0]    c0_i,
    input  logic [DATA_W-1:0]    a1_i,
    input  logic [DATA_W-1:0]    b1_i,
    input  logic [DATA_W-1:0]    c1_i,
    input  logic [DATA_W/32-1:0] e0_i,
    input  logic [DATA_W/32-1:0] e1_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CNT_W-1:0]     pass_cnt_o,
    output logic [CNT_W-1:0]     fail_cnt_o,
    output logic [CNT_W-1:0]     first_fail_o,
    output logic [DATA_W/32-1:0] fail_mask_o,
    output logic                 fail_o
);

    localparam int               c_LANES    = DATA_W / 32;
    localparam logic [1:0]       c_ST_IDLE  = 2'd0;
    localparam logic [1:0]       c_ST_RUN   = 2'd1;
    localparam logic [1:0]       c_ST_DRAIN = 2'd2;
    localparam logic [1:0]       c_ST_DONE  = 2'd3;
    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    // Lane-width select: 0=32b 1=64b 2=128b 3=256b. A width that does not
    // tile DATA_W falls back to 32-bit lanes so lanes never straddle the bus.
    function automatic logic [1:0] f_decode_width(input logic [2:0] code);
        logic [1:0] sel;
        sel = 2'd0;
        case (code)
            3'b001:  if (DATA_W % 64 == 0)  sel = 2'd1;
            3'b011:  if (DATA_W % 128 == 0) sel = 2'd2;
            3'b111:  if (DATA_W % 256 == 0) sel = 2'd3;
            default: sel = 2'd0;
        endcase
        return sel;
    endfunction

    // Run configuration and control state
    logic [1:0]           r_state;
    logic [1:0]           r_wsel;
    logic                 r_bool;
    logic                 r_ext;
    logic [CNT_W-1:0]     r_n;
    logic [CNT_W-1:0]     r_acc;
    logic [CNT_W-1:0]     r_res_idx;
    logic [CNT_W-1:0]     r_pass;
    logic [CNT_W-1:0]     r_fail_cnt;
    logic [CNT_W-1:0]     r_first;
    logic [c_LANES-1:0]   r_mask;
    logic                 r_fail;

    // Pipeline state
    logic                 r_s0_vld;
    logic [DATA_W-1:0]    r_s0_a;
    logic [DATA_W-1:0]    r_s0_b;
    logic [DATA_W-1:0]    r_s0_c;
    logic [c_LANES-1:0]   r_s0_e;
    logic [MUL_STAGES-1:0] r_mul_vld;
    logic [DATA_W-1:0]    r_mul_exp [MUL_STAGES];
    logic [DATA_W-1:0]    r_mul_c   [MUL_STAGES];
    logic [c_LANES-1:0]   r_mul_xb  [MUL_STAGES];
    logic                 r_cmp_vld;
    logic [c_LANES-1:0]   r_cmp_mask;

    logic [DATA_W-1:0]    w_ra;
    logic [DATA_W-1:0]    w_rb;
    logic [DATA_W-1:0]    w_rc;
    logic [DATA_W-1:0]    w_exp;
    logic [c_LANES-1:0]   w_ext_bad;
    logic [c_LANES-1:0]   w_n32;
    logic [c_LANES-1:0]   w_lane_bad;
    logic                 w_accept;
    logic                 w_pipe_busy;
    logic [CNT_W-1:0]     w_acc_nxt;

    assign w_accept    = (r_state == c_ST_RUN) && vld_i && !clear_i;
    assign w_pipe_busy = r_s0_vld || (|r_mul_vld) || r_cmp_vld;
    assign w_acc_nxt   = r_acc + c_CNT_ONE;

    // Reconstruct a, b, c: XOR in bool mode, carry-isolated lane add otherwise
    always_comb begin
        w_ra = a0_i ^ a1_i;
        w_rb = b0_i ^ b1_i;
        w_rc = c0_i ^ c1_i;
        if (!r_bool) begin
            case (r_wsel)
                2'd1: for (int l = 0; l < DATA_W / 64; l++) begin
                    w_ra[l*64 +: 64] = a0_i[l*64 +: 64] + a1_i[l*64 +: 64];
                    w_rb[l*64 +: 64] = b0_i[l*64 +: 64] + b1_i[l*64 +: 64];
                    w_rc[l*64 +: 64] = c0_i[l*64 +: 64] + c1_i[l*64 +: 64];
                end
                2'd2: for (int l = 0; l < DATA_W / 128; l++) begin
                    w_ra[l*128 +: 128] = a0_i[l*128 +: 128] + a1_i[l*128 +: 128];
                    w_rb[l*128 +: 128] = b0_i[l*128 +: 128] + b1_i[l*128 +: 128];
                    w_rc[l*128 +: 128] = c0_i[l*128 +: 128] + c1_i[l*128 +: 128];
                end
                2'd3: for (int l = 0; l < DATA_W / 256; l++) begin
                    w_ra[l*256 +: 256] = a0_i[l*256 +: 256] + a1_i[l*256 +: 256];
                    w_rb[l*256 +: 256] = b0_i[l*256 +: 256] + b1_i[l*256 +: 256];
                    w_rc[l*256 +: 256] = c0_i[l*256 +: 256] + c1_i[l*256 +: 256];
                end
                default: for (int l = 0; l < c_LANES; l++) begin
                    w_ra[l*32 +: 32] = a0_i[l*32 +: 32] + a1_i[l*32 +: 32];
                    w_rb[l*32 +: 32] = b0_i[l*32 +: 32] + b1_i[l*32 +: 32];
                    w_rc[l*32 +: 32] = c0_i[l*32 +: 32] + c1_i[l*32 +: 32];
                end
            endcase
        end
    end

    // Stage S0: register reconstructed values and valid
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_s0_vld <= 1'b0;
        end else begin
            r_s0_vld <= w_accept;
        end
        r_s0_a <= w_ra;
        r_s0_b <= w_rb;
        r_s0_c <= w_rc;
        r_s0_e <= e0_i ^ e1_i;
    end

    // Expected c: a&b in bool mode, lane-wise product mod 2^W otherwise
    always_comb begin
        w_exp = r_s0_a & r_s0_b;
        if (!r_bool) begin
            case (r_wsel)
                2'd1: for (int l = 0; l < DATA_W / 64; l++)
                    w_exp[l*64 +: 64] = r_s0_a[l*64 +: 64] * r_s0_b[l*64 +: 64];
                2'd2: for (int l = 0; l < DATA_W / 128; l++)
                    w_exp[l*128 +: 128] = r_s0_a[l*128 +: 128] * r_s0_b[l*128 +: 128];
                2'd3: for (int l = 0; l < DATA_W / 256; l++)
                    w_exp[l*256 +: 256] = r_s0_a[l*256 +: 256] * r_s0_b[l*256 +: 256];
                default: for (int l = 0; l < c_LANES; l++)
                    w_exp[l*32 +: 32] = r_s0_a[l*32 +: 32] * r_s0_b[l*32 +: 32];
            endcase
        end
    end

    // Extended-bit check: combined party bit k must match a[32k]
    always_comb begin
        w_ext_bad = '0;
        for (int k = 0; k < c_LANES; k++)
            w_ext_bad[k] = r_ext && (r_s0_e[k] != r_s0_a[32*k]);
    end

    // Multiplier pipeline valids; flushed by abort
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_mul_vld <= '0;
        end else begin
            r_mul_vld[0] <= r_s0_vld;
            for (int i = 1; i < MUL_STAGES; i++)
                r_mul_vld[i] <= r_mul_vld[i-1];
        end
    end

    // Multiplier pipeline data; registers give the synthesis tool room to retime the product
    always_ff @(posedge clk_i) begin
        r_mul_exp[0] <= w_exp;
        r_mul_c[0]   <= r_s0_c;
        r_mul_xb[0]  <= w_ext_bad;
        for (int i = 1; i < MUL_STAGES; i++) begin
            r_mul_exp[i] <= r_mul_exp[i-1];
            r_mul_c[i]   <= r_mul_c[i-1];
            r_mul_xb[i]  <= r_mul_xb[i-1];
        end
    end

    // Per-32-bit compare, then spread each wide-lane mismatch over its sub-lanes
    always_comb begin
        w_n32      = '0;
        w_lane_bad = '0;
        for (int k = 0; k < c_LANES; k++)
            w_n32[k] = r_mul_exp[MUL_STAGES-1][32*k +: 32] != r_mul_c[MUL_STAGES-1][32*k +: 32];
        for (int k = 0; k < c_LANES; k++)
            for (int j = 0; j < c_LANES; j++)
                if ((j >> r_wsel) == (k >> r_wsel))
                    w_lane_bad[k] = w_lane_bad[k] | w_n32[j];
    end

    // Compare stage: register the final sub-lane mismatch mask
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_cmp_vld <= 1'b0;
        end else begin
            r_cmp_vld <= r_mul_vld[MUL_STAGES-1];
        end
        r_cmp_mask <= w_lane_bad | r_mul_xb[MUL_STAGES-1];
    end

    // Control FSM with saturating result counters and first-failure capture
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= c_ST_IDLE;
            r_wsel     <= 2'd0;
            r_bool     <= 1'b0;
            r_ext      <= 1'b0;
            r_n        <= '0;
            r_acc      <= '0;
            r_res_idx  <= '0;
            r_pass     <= '0;
            r_fail_cnt <= '0;
            r_first    <= '0;
            r_mask     <= '0;
            r_fail     <= 1'b0;
        end else if (clear_i) begin
            r_state <= c_ST_IDLE;
        end else begin
            if (r_cmp_vld && (r_state == c_ST_RUN || r_state == c_ST_DRAIN)) begin
                if (r_cmp_mask == '0) begin
                    if (r_pass != c_CNT_MAX) r_pass <= r_pass + c_CNT_ONE;
                end else begin
                    if (r_fail_cnt != c_CNT_MAX) r_fail_cnt <= r_fail_cnt + c_CNT_ONE;
                    if (!r_fail) begin
                        r_fail  <= 1'b1;
                        r_first <= r_res_idx;
                        r_mask  <= r_cmp_mask;
                    end
                end
                if (r_res_idx != c_CNT_MAX) r_res_idx <= r_res_idx + c_CNT_ONE;
            end
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (start_i) begin
                        r_bool     <= (mode_i == 3'b010);
                        r_ext      <= (mode_i == 3'b001);
                        // Bool compare is bitwise, so report at 32-bit granularity
                        r_wsel     <= (mode_i == 3'b010) ? 2'd0 : f_decode_width(width_i);
                        r_n        <= n_triples_i;
                        r_acc      <= '0;
                        r_res_idx  <= '0;
                        r_pass     <= '0;
                        r_fail_cnt <= '0;
                        r_first    <= '0;
                        r_mask     <= '0;
                        r_fail     <= 1'b0;
                        r_state    <= (n_triples_i == '0) ? c_ST_DONE : c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    if (vld_i) begin
                        r_acc <= w_acc_nxt;
                        if (w_acc_nxt == r_n) r_state <= c_ST_DRAIN;
                    end
                end
                c_ST_DRAIN: begin
                    if (!w_pipe_busy) r_state <= c_ST_DONE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign busy_o       = (r_state == c_ST_RUN) || (r_state == c_ST_DRAIN);
    assign done_o       = (r_state == c_ST_DONE);
    assign pass_cnt_o   = r_pass;
    assign fail_cnt_o   = r_fail_cnt;
    assign first_fail_o = r_first;
    assign fail_mask_o  = r_mask;
    assign fail_o       = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_triple_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_triple_checker
//  Description : Directed self-checking bench for triple_checker.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_triple_checker;

    localparam int DATA_W     = 256;
    localparam int CNT_W      = 32;
    localparam int MUL_STAGES = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start, clear, vld;
    logic [2:0]        width, mode;
    logic [CNT_W-1:0]  n_triples;
    logic [DATA_W-1:0] a0, b0, c0, a1, b1, c1;
    logic [7:0]        e0, e1;
    logic              busy, done, fail_flag;
    logic [CNT_W-1:0]  pass_cnt, fail_cnt, first_fail;
    logic [7:0]        fail_mask;

    int checks_total  = 0;
    int checks_passed = 0;
    int cyc = 0;
    int lat;

    logic [255:0] ta [16];
    logic [255:0] tb [16];
    logic [255:0] tc [16];
    logic [7:0]   te [16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    triple_checker #(.DATA_W(DATA_W), .CNT_W(CNT_W), .MUL_STAGES(MUL_STAGES)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear),
        .width_i(width), .mode_i(mode), .n_triples_i(n_triples), .vld_i(vld),
        .a0_i(a0), .b0_i(b0), .c0_i(c0), .a1_i(a1), .b1_i(b1), .c1_i(c1),
        .e0_i(e0), .e1_i(e1),
        .busy_o(busy), .done_o(done), .pass_cnt_o(pass_cnt), .fail_cnt_o(fail_cnt),
        .first_fail_o(first_fail), .fail_mask_o(fail_mask), .fail_o(fail_flag)
    );

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [255:0] rnd256();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Replicate the low lw bits of v across the bus
    function automatic logic [255:0] rep(input logic [255:0] v, input int lw);
        case (lw)
            32:      return {8{v[31:0]}};
            64:      return {4{v[63:0]}};
            128:     return {2{v[127:0]}};
            default: return v;
        endcase
    endfunction

    // Lane-wise x - r modulo 2^lw
    function automatic logic [255:0] lane_sub(input logic [255:0] x, input logic [255:0] r, input int lw);
        logic [255:0] o;
        o = x - r;
        if (lw == 32)  for (int l = 0; l < 8; l++) o[l*32 +: 32]   = x[l*32 +: 32]   - r[l*32 +: 32];
        if (lw == 64)  for (int l = 0; l < 4; l++) o[l*64 +: 64]   = x[l*64 +: 64]   - r[l*64 +: 64];
        if (lw == 128) for (int l = 0; l < 2; l++) o[l*128 +: 128] = x[l*128 +: 128] - r[l*128 +: 128];
        return o;
    endfunction

    task automatic drive_shares(input int i, input int lw, input logic is_bool);
        logic [255:0] r;
        r = rnd256(); a0 = r; a1 = is_bool ? (ta[i] ^ r) : lane_sub(ta[i], r, lw);
        r = rnd256(); b0 = r; b1 = is_bool ? (tb[i] ^ r) : lane_sub(tb[i], r, lw);
        r = rnd256(); c0 = r; c1 = is_bool ? (tc[i] ^ r) : lane_sub(tc[i], r, lw);
        e0 = 8'($urandom()); e1 = te[i] ^ e0;
    endtask

    // Start a run, stream n triples back to back, wait (bounded) for done.
    // lat = posedges from the first accepting edge to the edge entering DONE.
    task automatic run_triples(input logic [2:0] w, input logic [2:0] m, input int n,
                               input int lw, input logic is_bool, input string tag, output int latency);
        int first_edge;
        int k;
        @(negedge clk);
        start = 1'b1; width = w; mode = m; n_triples = CNT_W'(n);
        @(negedge clk);
        start = 1'b0;
        first_edge = cyc + 1;
        for (int i = 0; i < n; i++) begin
            drive_shares(i, lw, is_bool);
            vld = 1'b1;
            @(negedge clk);
        end
        vld = 1'b0;
        k = 0;
        while (!done && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_value({tag, "_done"}, 64'(done), 64'd1);
        latency = cyc - first_edge;
    endtask

    task automatic fill_arith(input int lw, input int n);
        for (int i = 0; i < n; i++) begin
            ta[i] = rep(256'd3, lw);
            tb[i] = rep(256'd5, lw);
            tc[i] = rep(256'd15, lw);
            te[i] = 8'h00;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; clear = 1'b0; vld = 1'b0;
        width = 3'b000; mode = 3'b100; n_triples = '0;
        a0 = '0; b0 = '0; c0 = '0; a1 = '0; b1 = '0; c1 = '0; e0 = '0; e1 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_value("rst_busy", 64'(busy), 64'd0);
        check_value("rst_done", 64'(done), 64'd0);
        check_value("rst_pass", 64'(pass_cnt), 64'd0);
        check_value("rst_fail", 64'(fail_cnt), 64'd0);
        check_value("rst_flag", 64'(fail_flag), 64'd0);

        // 1: all-correct 256-bit arith, latency n + MUL_STAGES + 2
        fill_arith(256, 4);
        run_triples(3'b111, 3'b100, 4, 256, 1'b0, "t1", lat);
        check_value("t1_lat",  64'(lat), 64'(4 + MUL_STAGES + 2));
        check_value("t1_pass", 64'(pass_cnt), 64'd4);
        check_value("t1_fail", 64'(fail_cnt), 64'd0);
        check_value("t1_flag", 64'(fail_flag), 64'd0);

        // 2: 32-bit lanes, triple 6 lane 2 off by one
        fill_arith(32, 10);
        tc[6][95:64] = 32'd16;
        run_triples(3'b000, 3'b100, 10, 32, 1'b0, "t2", lat);
        check_value("t2_pass",  64'(pass_cnt), 64'd9);
        check_value("t2_fail",  64'(fail_cnt), 64'd1);
        check_value("t2_first", 64'(first_fail), 64'd6);
        check_value("t2_mask",  64'(fail_mask), 64'h04);

        // 3: 128-bit lanes, triple 0 high lane wrong
        fill_arith(128, 3);
        tc[0][255:128] = 128'd16;
        run_triples(3'b011, 3'b100, 3, 128, 1'b0, "t3", lat);
        check_value("t3_first", 64'(first_fail), 64'd0);
        check_value("t3_mask",  64'(fail_mask), 64'hF0);
        check_value("t3_flag",  64'(fail_flag), 64'd1);
        check_value("t3_pass",  64'(pass_cnt), 64'd2);

        // 4: bool, a = all ones so c = b; then flip c bit 40
        ta[0] = '1;
        tb[0] = 256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0F0F_F0F0_55AA_AA55_DEAD_BEEF_CAFE_F00D;
        tc[0] = tb[0];
        te[0] = 8'h00;
        run_triples(3'b011, 3'b010, 1, 256, 1'b1, "t4a", lat);
        check_value("t4a_pass", 64'(pass_cnt), 64'd1);
        check_value("t4a_fail", 64'(fail_cnt), 64'd0);
        tc[0][40] = ~tc[0][40];
        run_triples(3'b011, 3'b010, 1, 256, 1'b1, "t4b", lat);
        check_value("t4b_fail", 64'(fail_cnt), 64'd1);
        check_value("t4b_mask", 64'(fail_mask), 64'h02);

        // 5: extended 64-bit; a lanes = 3 give LSB pattern 0x55, bit 3 flipped
        fill_arith(64, 1);
        te[0] = 8'h55 ^ 8'h08;
        run_triples(3'b001, 3'b001, 1, 64, 1'b0, "t5", lat);
        check_value("t5_mask", 64'(fail_mask), 64'h08);
        check_value("t5_fail", 64'(fail_cnt), 64'd1);
        check_value("t5_pass", 64'(pass_cnt), 64'd0);

        // 6a: n = 0 completes the cycle after start with cleared results
        @(negedge clk);
        start = 1'b1; width = 3'b000; mode = 3'b100; n_triples = '0;
        @(negedge clk);
        start = 1'b0;
        check_value("t6_done", 64'(done), 64'd1);
        check_value("t6_pass", 64'(pass_cnt), 64'd0);
        check_value("t6_fail", 64'(fail_cnt), 64'd0);
        check_value("t6_flag", 64'(fail_flag), 64'd0);

        // 6b: abort mid-run; in-flight results must not be counted
        fill_arith(32, 5);
        start = 1'b1; n_triples = CNT_W'(5);
        @(negedge clk);
        start = 1'b0;
        check_value("t6_busy_run", 64'(busy), 64'd1);
        for (int i = 0; i < 2; i++) begin
            drive_shares(i, 32, 1'b0);
            vld = 1'b1;
            @(negedge clk);
        end
        vld = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_value("t6_busy_clr", 64'(busy), 64'd0);
        repeat (12) @(negedge clk);
        check_value("t6_late_pass", 64'(pass_cnt), 64'd0);
        check_value("t6_late_done", 64'(done), 64'd0);
        check_value("t6_late_busy", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
`default_nettype wire
